// File: rtl/demux_dispatch_ctrl_if.sv
// Handshake bundle for demux_dispatch_ctrl: one producer stream in, four sink channels out.
// Valid/ready: a beat moves on a rising clk edge where valid and ready are both high; a raised out_valid holds with stable out_data until that edge.
interface demux_dispatch_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [3:0]        out_valid;
  logic [DATA_W-1:0] out_data;
  logic [3:0]        out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/demux_dispatch_ctrl.sv
// 1-to-4 dispatch controller: one holding register steered round-robin or by sel to four sinks.
// Optional stall timeout that discards a stuck beat is enabled by defining DISPATCH_TIMEOUT_EN.
module demux_dispatch_ctrl #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [1:0]            sel,
  input  logic [3:0]            ch_en,
  demux_dispatch_ctrl_if.slave  bus,
  output logic [1:0]            cur_ch,
  output logic                  busy,
  output logic                  drop
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("demux_dispatch_ctrl: TIMEOUT must be at least 2");
  end

  state_e            state_q;
  logic [1:0]        rr_ptr_q;
  logic [1:0]        cur_ch_q;
  logic [3:0]        out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              drop_q;

  logic              cand_ok;
  logic [1:0]        cand_ch;
  logic [1:0]        scan_ch;
  logic              accept;
  logic              complete;

`ifdef DISPATCH_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  logic [STALL_W-1:0] stall_q;
`endif

  // Scan downwards so the closest enabled channel at or after rr_ptr wins.
  always_comb begin
    cand_ok = 1'b0;
    cand_ch = 2'd0;
    scan_ch = 2'd0;
    if (mode) begin
      cand_ok = ch_en[sel];
      cand_ch = sel;
    end else begin
      for (int i = 3; i >= 0; i--) begin
        scan_ch = rr_ptr_q + 2'(i);
        if (ch_en[scan_ch]) begin
          cand_ok = 1'b1;
          cand_ch = scan_ch;
        end
      end
    end
  end

  // In SEND a new beat may enter only on the cycle the held one leaves.
  assign complete     = (state_q == SEND) && bus.out_ready[cur_ch_q];
  assign bus.in_ready = cand_ok && ((state_q == IDLE) || bus.out_ready[cur_ch_q]);
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 2'd0;
      cur_ch_q    <= 2'd0;
      out_valid_q <= 4'b0000;
      out_data_q  <= '0;
      drop_q      <= 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
      stall_q     <= '0;
`endif
    end else begin
      drop_q <= 1'b0;
      if (accept) begin
        state_q     <= SEND;
        cur_ch_q    <= cand_ch;
        out_valid_q <= 4'b0001 << cand_ch;
        out_data_q  <= bus.in_data;
        if (!mode) begin
          rr_ptr_q <= cand_ch + 2'd1;
        end
      end else if (complete) begin
        state_q     <= IDLE;
        out_valid_q <= 4'b0000;
      end
`ifdef DISPATCH_TIMEOUT_EN
      else if ((state_q == SEND) && (stall_q == STALL_W'(TIMEOUT - 1))) begin
        state_q     <= IDLE;
        out_valid_q <= 4'b0000;
        drop_q      <= 1'b1;
      end
      if (accept || complete) begin
        stall_q <= '0;
      end else if (state_q == SEND) begin
        stall_q <= stall_q + 1'b1;
      end
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign cur_ch        = cur_ch_q;
  assign busy          = (state_q == SEND);
  assign drop          = drop_q;

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Testbench for demux_dispatch_ctrl: directed scenarios plus randomized traffic against a
// beat-level reference model and a delivery scoreboard.
module tb_demux_dispatch_ctrl;
  localparam int DW = 8;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode = 1'b0;
  logic [1:0] sel = 2'd0;
  logic [3:0] ch_en = 4'b0000;
  logic [1:0] cur_ch;
  logic       busy;
  logic       drop;

  int n_vec = 0;
  int n_err = 0;

  demux_dispatch_ctrl_if #(.DATA_W(DW)) bus ();

  demux_dispatch_ctrl #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (mode),
    .sel   (sel),
    .ch_en (ch_en),
    .bus   (bus),
    .cur_ch(cur_ch),
    .busy  (busy),
    .drop  (drop)
  );

  always #5 clk = ~clk;

  // Reference model: the controller is a one-beat slot plus a round-robin pointer.
  logic          m_held = 1'b0;
  logic [1:0]    m_ch = 2'd0;
  logic [DW-1:0] m_data = '0;
  logic          m_drop = 1'b0;
  int            m_rr = 0;
  int            m_stall = 0;
  logic [DW+1:0] exp_q[$];
  logic [DW+1:0] got_q[$];

  function automatic int pick();
    if (mode) return ch_en[sel] ? int'(sel) : -1;
    for (int k = 0; k < 4; k++) begin
      if (ch_en[(m_rr + k) % 4]) return (m_rr + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic exp_ready();
    return (pick() >= 0) && (!m_held || bus.out_ready[m_ch]);
  endfunction

  always @(posedge clk) begin
    int   c;
    logic acc;
    logic done;
    if (!rst_n) begin
      if (m_held) void'(exp_q.pop_back());
      m_held = 1'b0; m_ch = 2'd0; m_data = '0; m_drop = 1'b0; m_rr = 0; m_stall = 0;
    end else begin
      c    = pick();
      acc  = bus.in_valid && exp_ready();
      done = m_held && bus.out_ready[m_ch];
      m_drop = 1'b0;
      if (acc) begin
        exp_q.push_back({2'(c), bus.in_data});
        if (!mode) m_rr = (c + 1) % 4;
        m_held = 1'b1; m_ch = 2'(c); m_data = bus.in_data; m_stall = 0;
      end else if (done) begin
        m_held = 1'b0;
      end else if (m_held) begin
        m_stall++;
`ifdef DISPATCH_TIMEOUT_EN
        if (m_stall == TO) begin
          m_held = 1'b0; m_drop = 1'b1;
          void'(exp_q.pop_back());
        end
`endif
      end
    end
  end

  // Delivery monitor: logs every beat a sink actually takes.
  always @(negedge clk) begin
    logic [1:0] ch;
    #2;
    ch = 2'd0;
    if (rst_n === 1'b1 && (bus.out_valid & bus.out_ready) != 4'b0000) begin
      for (int k = 0; k < 4; k++) if (bus.out_valid[k] && bus.out_ready[k]) ch = 2'(k);
      got_q.push_back({ch, bus.out_data});
    end
  end

  task automatic drive(input logic m, input logic [1:0] s, input logic [3:0] e,
                       input logic v, input logic [DW-1:0] d, input logic [3:0] r);
    @(negedge clk);
    mode = m; sel = s; ch_en = e;
    bus.in_valid = v; bus.in_data = d; bus.out_ready = r;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 1'b0; ch_en = 4'hF;
    bus.in_valid = 1'b1; bus.in_data = 8'hFF; bus.out_ready = 4'b0000;
    repeat (3) @(negedge clk);
    #1;
    n_vec++; if (bus.out_valid !== 4'b0000) begin n_err++; $display("FAIL reset_out_valid: got %b want 0000", bus.out_valid); end
    n_vec++; if (bus.out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %h want 00", bus.out_data); end
    n_vec++; if (cur_ch !== 2'd0) begin n_err++; $display("FAIL reset_cur_ch: got %0d want 0", cur_ch); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (drop !== 1'b0) begin n_err++; $display("FAIL reset_drop: got %b want 0", drop); end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_rr_sweep();
    logic [3:0] ev;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 2'd0, 4'hF, i < 6, DW'(8'hA0 + i), 4'hF);
      if (i < 6) begin
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rr_in_ready beat %0d: got %b want 1", i, bus.in_ready); end
      end
      if (i > 0) begin
        ev = 4'b0001 << ((i - 1) % 4);
        n_vec++; if (bus.out_valid !== ev) begin n_err++; $display("FAIL rr_out_valid beat %0d: got %b want %b", i - 1, bus.out_valid, ev); end
        n_vec++; if (bus.out_data !== DW'(8'hA0 + i - 1)) begin n_err++; $display("FAIL rr_out_data beat %0d: got %h want %h", i - 1, bus.out_data, DW'(8'hA0 + i - 1)); end
      end
    end
    drive(1'b0, 2'd0, 4'hF, 1'b0, 8'h00, 4'hF);
    n_vec++; if (bus.out_valid !== 4'b0000) begin n_err++; $display("FAIL rr_drain: got %b want 0000", bus.out_valid); end
  endtask

  task automatic test_rr_mask();
    int exp_ch[3] = '{1, 3, 1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'd0, 4'b1010, i < 3, DW'(8'h30 + i), 4'hF);
      if (i > 0) begin
        n_vec++; if (bus.out_valid !== (4'b0001 << exp_ch[i - 1])) begin n_err++; $display("FAIL mask_out_valid beat %0d: got %b want ch%0d", i - 1, bus.out_valid, exp_ch[i - 1]); end
        n_vec++; if (bus.out_data !== DW'(8'h30 + i - 1)) begin n_err++; $display("FAIL mask_out_data beat %0d: got %h want %h", i - 1, bus.out_data, DW'(8'h30 + i - 1)); end
      end
    end
    repeat (2) begin
      drive(1'b0, 2'd0, 4'b0000, 1'b1, 8'h99, 4'hF);
      n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL mask_none_ready: got %b want 0", bus.in_ready); end
      n_vec++; if (bus.out_valid !== 4'b0000) begin n_err++; $display("FAIL mask_none_valid: got %b want 0000", bus.out_valid); end
    end
    drive(1'b0, 2'd0, 4'b0000, 1'b0, 8'h00, 4'hF);
  endtask

  task automatic test_fixed_stall();
    drive(1'b1, 2'd2, 4'hF, 1'b1, 8'h5C, 4'b0000);
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL stall_accept: got %b want 1", bus.in_ready); end
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 2'd2, 4'hF, 1'b1, 8'h11, (k == 2 || k == 3) ? 4'b0001 : 4'b0000);
      n_vec++; if (bus.out_valid !== 4'b0100) begin n_err++; $display("FAIL stall_out_valid cyc %0d: got %b want 0100", k, bus.out_valid); end
      n_vec++; if (bus.out_data !== 8'h5C) begin n_err++; $display("FAIL stall_out_data cyc %0d: got %h want 5c", k, bus.out_data); end
      n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready cyc %0d: got %b want 0", k, bus.in_ready); end
    end
    drive(1'b1, 2'd2, 4'hF, 1'b0, 8'h00, 4'b0100);
    n_vec++; if (bus.out_valid !== 4'b0100 || bus.out_data !== 8'h5C) begin n_err++; $display("FAIL stall_release: got %b/%h want 0100/5c", bus.out_valid, bus.out_data); end
    drive(1'b1, 2'd2, 4'hF, 1'b0, 8'h00, 4'b0000);
    n_vec++; if (bus.out_valid !== 4'b0000 || busy !== 1'b0) begin n_err++; $display("FAIL stall_idle: got %b busy %b want 0000 busy 0", bus.out_valid, busy); end
  endtask

  task automatic test_fixed_masked();
    repeat (2) begin
      drive(1'b1, 2'd1, 4'b1101, 1'b1, 8'h3B, 4'hF);
      n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL fixmask_in_ready: got %b want 0", bus.in_ready); end
      n_vec++; if (bus.out_valid !== 4'b0000) begin n_err++; $display("FAIL fixmask_out_valid: got %b want 0000", bus.out_valid); end
    end
    drive(1'b1, 2'd1, 4'hF, 1'b1, 8'h3B, 4'hF);
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL fixmask_enable: got %b want 1", bus.in_ready); end
    drive(1'b1, 2'd1, 4'hF, 1'b0, 8'h00, 4'hF);
    n_vec++; if (bus.out_valid !== 4'b0010 || bus.out_data !== 8'h3B || cur_ch !== 2'd1) begin n_err++; $display("FAIL fixmask_deliver: got %b/%h ch%0d want 0010/3b ch1", bus.out_valid, bus.out_data, cur_ch); end
    drive(1'b1, 2'd1, 4'hF, 1'b0, 8'h00, 4'hF);
  endtask

  task automatic test_reset_in_send();
    do_reset();
    drive(1'b0, 2'd0, 4'hF, 1'b1, 8'h12, 4'b0000);
    drive(1'b0, 2'd0, 4'hF, 1'b1, 8'h77, 4'b0001);
    drive(1'b0, 2'd0, 4'hF, 1'b0, 8'h00, 4'b0000);
    n_vec++; if (busy !== 1'b1 || bus.out_valid !== 4'b0010 || bus.out_data !== 8'h77) begin n_err++; $display("FAIL rsend_hold: got busy %b %b/%h want busy 1 0010/77", busy, bus.out_valid, bus.out_data); end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++; if (bus.out_valid !== 4'b0000 || busy !== 1'b0 || cur_ch !== 2'd0) begin n_err++; $display("FAIL rsend_cleared: got %b busy %b ch%0d want 0000 busy 0 ch0", bus.out_valid, busy, cur_ch); end
    drive(1'b0, 2'd0, 4'hF, 1'b1, 8'h44, 4'b0000);
    drive(1'b0, 2'd0, 4'hF, 1'b0, 8'h00, 4'b0000);
    n_vec++; if (bus.out_valid !== 4'b0001 || bus.out_data !== 8'h44) begin n_err++; $display("FAIL rsend_next: got %b/%h want 0001/44", bus.out_valid, bus.out_data); end
    drive(1'b0, 2'd0, 4'hF, 1'b0, 8'h00, 4'hF);
  endtask

  task automatic test_timeout();
    drive(1'b0, 2'd0, 4'hF, 1'b1, 8'hE5, 4'b0000);
`ifdef DISPATCH_TIMEOUT_EN
    for (int k = 1; k <= TO; k++) begin
      drive(1'b0, 2'd0, 4'hF, 1'b0, 8'h00, 4'b0000);
      n_vec++; if ($countones(bus.out_valid) != 1 || drop !== 1'b0) begin n_err++; $display("FAIL to_hold cyc %0d: got %b drop %b want one-hot drop 0", k, bus.out_valid, drop); end
    end
    drive(1'b0, 2'd0, 4'hF, 1'b0, 8'h00, 4'b0000);
    n_vec++; if (bus.out_valid !== 4'b0000 || drop !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL to_drop: got %b drop %b busy %b want 0000 drop 1 busy 0", bus.out_valid, drop, busy); end
    drive(1'b0, 2'd0, 4'hF, 1'b1, 8'h5A, 4'b0000);
    n_vec++; if (drop !== 1'b0 || bus.in_ready !== 1'b1) begin n_err++; $display("FAIL to_after: got drop %b in_ready %b want 0 1", drop, bus.in_ready); end
    drive(1'b0, 2'd0, 4'hF, 1'b0, 8'h00, 4'hF);
    n_vec++; if ($countones(bus.out_valid) != 1 || bus.out_data !== 8'h5A) begin n_err++; $display("FAIL to_next: got %b/%h want one-hot/5a", bus.out_valid, bus.out_data); end
`else
    for (int k = 1; k <= 40; k++) begin
      drive(1'b0, 2'd0, 4'hF, 1'b0, 8'h00, 4'b0000);
      n_vec++; if ($countones(bus.out_valid) != 1 || bus.out_data !== 8'hE5 || drop !== 1'b0) begin n_err++; $display("FAIL to_hold cyc %0d: got %b/%h drop %b want one-hot/e5 drop 0", k, bus.out_valid, bus.out_data, drop); end
    end
    drive(1'b0, 2'd0, 4'hF, 1'b0, 8'h00, 4'hF);
`endif
    drive(1'b0, 2'd0, 4'hF, 1'b0, 8'h00, 4'hF);
    n_vec++; if (bus.out_valid !== 4'b0000) begin n_err++; $display("FAIL to_idle: got %b want 0000", bus.out_valid); end
  endtask

  task automatic test_random();
    logic [3:0] ev;
    logic [3:0] e;
    logic [3:0] r;
    for (int i = 0; i < 500; i++) begin
      e = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      if (i < 300) r = 4'($urandom_range(0, 15));
      else         r = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      drive($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), e,
            $urandom_range(0, 3) != 0, DW'($urandom_range(0, 255)), r);
      ev = m_held ? (4'b0001 << m_ch) : 4'b0000;
      n_vec++; if (bus.out_valid !== ev) begin n_err++; $display("FAIL rand_out_valid cyc %0d: got %b want %b", i, bus.out_valid, ev); end
      n_vec++; if (bus.in_ready !== exp_ready()) begin n_err++; $display("FAIL rand_in_ready cyc %0d: got %b want %b", i, bus.in_ready, exp_ready()); end
      n_vec++; if (busy !== m_held || drop !== m_drop) begin n_err++; $display("FAIL rand_busy_drop cyc %0d: got %b/%b want %b/%b", i, busy, drop, m_held, m_drop); end
      if (m_held) begin
        n_vec++; if (bus.out_data !== m_data || cur_ch !== m_ch) begin n_err++; $display("FAIL rand_held cyc %0d: got %h ch%0d want %h ch%0d", i, bus.out_data, cur_ch, m_data, m_ch); end
      end
    end
    repeat (4) drive(1'b0, 2'd0, 4'hF, 1'b0, 8'h00, 4'hF);
  endtask

  task automatic test_scoreboard();
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL sb_count: got %0d beats want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL sb_beat %0d: got ch%0d/%h want ch%0d/%h", i, got_q[i][DW+1:DW], got_q[i][DW-1:0], exp_q[i][DW+1:DW], exp_q[i][DW-1:0]);
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 4'b0000;
    test_reset();
    test_rr_sweep();
    test_rr_mask();
    test_fixed_stall();
    test_fixed_masked();
    test_reset_in_send();
    test_timeout();
    test_random();
    test_scoreboard();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/demux_dispatch_ctrl.md
Name: demux_dispatch_ctrl

Overview:
Sequencing controller for the 1-to-4 demultiplexer. It accepts a single valid/ready input stream, holds each beat in one output register, and steers it to one of four sink channels. Channel choice is either round-robin over enabled channels or fixed by a select input. It sits between a single producer and four consumers, and provides back-to-back throughput when the chosen sink is ready.

Parameters:
DATA_W, 8, width of the data beat.
TIMEOUT, 16, stall cycles before a held beat is dropped (used only with the optional feature); must be at least 2.

Ports:
clk  in  1  system clock; all state changes on rising edge.
rst_n  in  1  synchronous active-low reset.
mode  in  1  0 = round-robin over enabled channels; 1 = fixed channel from sel.
sel  in  2  fixed-mode target channel.
ch_en  in  4  per-channel enable mask; bit n enables channel n.
in_valid  in  1  producer beat valid.
in_data  in  DATA_W  producer beat data.
in_ready  out  1  controller can accept a beat this cycle.
out_valid  out  4  one-hot valid to sinks; all zeros when idle.
out_data  out  DATA_W  shared data bus to all sinks.
out_ready  in  4  per-sink ready.
cur_ch  out  2  channel of the beat currently held.
busy  out  1  high while a beat is held (state SEND).
drop  out  1  one-cycle pulse when a beat is discarded on timeout (optional feature only).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, rr_ptr=0, out_valid=0, out_data=0, cur_ch=0, busy=0, drop=0.
  - Reset overrides everything, including a beat that is mid-handshake; that beat is lost.
- Channel pick, combinational, computed from current inputs:
  - mode=0: first n with ch_en[n]=1, searching rr_ptr, rr_ptr+1, ... modulo 4. If ch_en=0000, there is no candidate.
  - mode=1: candidate is sel only if ch_en[sel]=1; otherwise there is no candidate.
- State IDLE:
  - in_ready = 1 if a candidate exists, else 0.
  - On in_valid && in_ready: capture in_data into out_data, set cur_ch=candidate, go to SEND. out_valid[candidate] rises on the next cycle, so entry latency is 1 cycle.
  - In round-robin mode, rr_ptr <= candidate+1 mod 4 (3 wraps to 0) on every accepted beat. rr_ptr is unchanged in fixed mode.
- State SEND:
  - out_valid = one-hot(cur_ch). out_data is held stable until the transfer completes.
  - Transfer completes when out_ready[cur_ch]=1. out_ready on any other channel is ignored.
  - in_ready = out_ready[cur_ch] && candidate exists. This allows pass-through for back-to-back beats.
  - Completion with a simultaneous new accept: load the new beat and cur_ch, stay in SEND. No bubble cycle.
  - Completion with no new accept: out_valid=0, go to IDLE.
  - Changes to mode, sel or ch_en while in SEND do not affect the held beat. They affect only the next pick, including a same-cycle accept.
- No beat is duplicated and none is reordered. Beats are dropped only by reset, or by the timeout when the optional feature is enabled.
- busy = (state==SEND).

Optional Feature:
DISPATCH_TIMEOUT_EN
- Defined:
  - A stall counter of width clog2(TIMEOUT+1) clears on entry to SEND and on every completion.
  - It increments each SEND cycle with out_ready[cur_ch]=0.
  - When it reaches TIMEOUT-1 with the sink still not ready, the beat is discarded: out_valid=0, drop=1 for one cycle, state goes to IDLE, and rr_ptr is unaffected.
- Undefined: no counter exists, drop is tied to 0, and SEND waits indefinitely.

Test Plan:
1. Reset, mode=0, ch_en=1111, all out_ready=1, send beats 0xA0..0xA5 back-to-back -> out_valid sequence 0001, 0010, 0100, 1000, 0001, 0010. Data matches in order. in_ready stays 1 and there is no idle cycle between beats.
2. mode=0, ch_en=1010, out_ready=1111, three beats -> delivered on ch1, ch3, ch1. Then set ch_en=0000 -> in_ready=0 in IDLE and no out_valid.
3. mode=1, sel=2, ch_en=1111. Beat 0x5C with out_ready[2]=0 for 5 cycles, then 1 -> out_valid=0100 and out_data=0x5C held for 6 cycles, in_ready=0 during the stall. Asserting out_ready[0] alone during the stall has no effect.
4. mode=1, sel=1, ch_en=1101 -> in_ready=0. Then change ch_en to 1111 -> beat accepted and delivered on ch1.
5. Assert rst_n=0 for one cycle while in SEND holding 0x77 -> next cycle out_valid=0000, busy=0, rr_ptr=0. The next beat in round-robin mode goes to ch0.
6. With DISPATCH_TIMEOUT_EN, TIMEOUT=16, out_ready=0000 -> beat held 16 cycles, then a drop pulse and out_valid=0000. A following beat is accepted normally. Without the macro, the beat is held indefinitely and drop stays 0.
